// File: rtl/icache_fill_controller.sv
// icache_fill_controller
//   Runs the fetch front end through an I-cache miss. It requests the unified
//   memory from the arbiter, issues one read per word of the missing block,
//   writes every returned word into the data array, writes the tag with the
//   last word, and holds the PC / bubbles IF/ID until the refetch can hit.
//
// Ports
//   clk, rst_n         clock, async active-low reset
//   miss_detected      lookup missed this cycle
//   miss_address       PC that missed
//   mem_grant          arbiter grant (level)
//   mem_data_valid     read data valid
//   mem_data           read data
//   mem_req            memory ownership request
//   mem_en, mem_addr   one read issued this cycle, and its address
//   write_data_array   write cache_data at cache_addr
//   write_tag_array    write tag/valid for the block at cache_addr
//   cache_addr         fill write address
//   cache_data         fill write data
//   pc_stall           freeze PC and IF/ID
//   if_id_flush        bubble into IF/ID
//   fsm_busy           fill in progress
module icache_fill_controller #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int OFFSET_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_grant,
  input  logic              mem_data_valid,
  input  logic [ADDR_W-1:0] mem_data,
  output logic              mem_req,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [ADDR_W-1:0] cache_data,
  output logic              pc_stall,
  output logic              if_id_flush,
  output logic              fsm_busy
);

  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, FILL, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   recv_cnt;
  logic [ADDR_W-1:0]  base;

  // Byte offset inside the block is discarded when the base is latched.
  logic unused_offset;
  assign unused_offset = &{1'b0, miss_address[OFFSET_W-1:0]};

  // Miss seen in IDLE; gated by rst_n so nothing leaks out while in reset.
  logic miss_go;
  logic issue;
  logic recv;
  logic last;

  assign miss_go = (state == IDLE) && miss_detected && rst_n;
  assign issue   = (state == FILL) && (issue_cnt < CNT_W'(BLOCK_WORDS));
  // Valids past the last word are dropped; recv_cnt saturates the block.
  assign recv    = (state == FILL) && mem_data_valid &&
                   (recv_cnt < CNT_W'(BLOCK_WORDS));
  assign last    = recv && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base      <= {miss_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= WAIT_GRANT;
          end
        end
        WAIT_GRANT: if (mem_grant) state <= FILL;
        FILL: begin
          if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
          if (recv)  recv_cnt  <= recv_cnt + CNT_W'(1);
          if (last)  state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request, issue and fill writes must act in the same cycle as the miss /
  // returned data, so these are decoded from state and inputs directly.
  // Offsets stay below the block size, so base + offset never carries into
  // the tag bits.
  always_comb begin
    mem_req          = (state == WAIT_GRANT) || (state == FILL) || miss_go;
    mem_en           = issue;
    mem_addr         = '0;
    write_data_array = recv;
    write_tag_array  = last;
    cache_addr       = '0;
    cache_data       = '0;
    if (issue) mem_addr = base + (ADDR_W'(issue_cnt) << 1);
    if (recv) begin
      cache_addr = base + (ADDR_W'(recv_cnt) << 1);
      cache_data = mem_data;
    end
    pc_stall    = (state != IDLE) || miss_go;
    if_id_flush = (state != IDLE) || miss_go;
    fsm_busy    = (state != IDLE);
  end

endmodule

// File: doc/icache_fill_controller.md
Name: icache_fill_controller

Overview:
- Sequences the instruction-fetch front end on an I-cache miss.
- Requests the shared unified memory through the memory arbiter, issues the eight word reads of the missing 16-byte block, and writes each returned word into the I-cache data array.
- Writes the tag on the final word.
- Holds the PC and bubbles the IF/ID pipeline register until the refetch can hit.

Parameters:
- ADDR_W, 16, address and data width in bits.
- BLOCK_WORDS, 8, 16-bit words per cache block (power of two).
- OFFSET_W, 4, byte-offset bits per block (log2(2*BLOCK_WORDS)).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- miss_detected  input  1  I-cache lookup missed this cycle
- miss_address  input  ADDR_W  fetch PC that missed
- mem_grant  input  1  arbiter grant of memory to I-fetch (level, held while mem_req high)
- mem_data_valid  input  1  memory read data valid this cycle
- mem_data  input  ADDR_W  memory read data
- mem_req  output  1  request memory ownership from arbiter
- mem_en  output  1  issue one read this cycle
- mem_addr  output  ADDR_W  read address
- write_data_array  output  1  write cache_data into data array at cache_addr
- write_tag_array  output  1  write tag/valid for block at cache_addr
- cache_addr  output  ADDR_W  fill write address
- cache_data  output  ADDR_W  fill write data (mirrors mem_data)
- pc_stall  output  1  freeze PC and IF/ID (drives IF/ID stall)
- if_id_flush  output  1  insert bubble into IF/ID (drives IF/ID flush)
- fsm_busy  output  1  fill in progress

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state=IDLE, issue_cnt=0, recv_cnt=0, base=0. All outputs are 0 during reset and until the first miss.
- States: IDLE, WAIT_GRANT, FILL, DONE.
- IDLE:
  - On miss_detected, latch base={miss_address[ADDR_W-1:OFFSET_W], OFFSET_W'b0} and clear both counters; next state WAIT_GRANT.
  - mem_req is asserted combinationally in the same cycle as miss_detected.
- WAIT_GRANT:
  - mem_req=1 and mem_en=0.
  - On mem_grant=1, go to FILL next cycle. Without grant, stay indefinitely.
- FILL, issue side:
  - mem_req=1.
  - While issue_cnt<BLOCK_WORDS: mem_en=1, mem_addr=base+2*issue_cnt, issue_cnt++ (one read per cycle, back-to-back).
  - Once issue_cnt==BLOCK_WORDS, mem_en=0.
- FILL, receive side (independent of issue side):
  - On mem_data_valid: write_data_array=1, cache_addr=base+2*recv_cnt, cache_data=mem_data, recv_cnt++.
  - Issue and receive may coincide in the same cycle.
- FILL exit:
  - The cycle carrying the BLOCK_WORDS-th valid also asserts write_tag_array=1 with cache_addr set to that word's address.
  - Next state DONE.
- DONE:
  - One cycle; mem_req=0 and mem_en=0.
  - miss_detected is ignored.
  - Always returns to IDLE, so the refetch is performed in IDLE.
- Stall and flush:
  - pc_stall=if_id_flush=1 when state!=IDLE, or when state==IDLE and miss_detected.
  - Deasserted in the IDLE cycle after DONE.
- fsm_busy: fsm_busy=(state!=IDLE).
- Outputs not listed as active in a state are 0. When inactive, mem_addr, cache_addr and cache_data are 0.
- Ignored input conditions:
  - mem_data_valid outside FILL.
  - mem_data_valid beyond BLOCK_WORDS.
  - mem_grant outside WAIT_GRANT.
- No abort: a fill always completes once started, even if the pipeline flushes for a mispredict.
- Arithmetic: address arithmetic is modulo 2^ADDR_W. The block at 0xFFF0 fills 0xFFF0..0xFFFE without carry into the tag.
- Reset mid-operation: asynchronous return to IDLE; no tag write is issued for the partial block.

Test Plan:
- Miss at 0x1236 in cycle 0, grant in cycle 1, memory latency 4:
  - mem_en in cycles 2-9 with addr 0x1230..0x123E step 2.
  - write_data_array in cycles 6-13.
  - write_tag_array only in cycle 13 with cache_addr 0x123E.
  - DONE in cycle 14; pc_stall/if_id_flush high in cycles 0-14, low in cycle 15.
- Grant withheld 5 cycles after miss at 0x0040 -> mem_req=1 and mem_en=0 throughout; first mem_en with addr 0x0040 the cycle after grant.
- Irregular valids (gaps of 0-3 cycles between returns) -> exactly 8 data writes at consecutive addresses in order; tag write coincides with the 8th.
- rst_n pulled low after 3 returned words -> all outputs 0 immediately; no write_tag_array; a new miss at 0x2000 restarts cleanly from 0x2000.
- Spurious mem_data_valid in IDLE and a 9th valid in DONE -> no write_data_array or write_tag_array.
- Miss at 0xFFFA -> addresses 0xFFF0..0xFFFE; wrap-free, no write outside the block.
